// File: rtl/clkgate_ctrl.sv
// Multi-channel auto clock-gate controller: per-channel idle countdown, OFF, and timed wake.
// Enable takes effect on the clk_in edge after en_q updates; a low-phase latch keeps clk_out glitch-free.
module clkgate_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              test_en,
    input  logic [IDLE_W-1:0] idle_thresh,
    input  logic [NUM_CH-1:0] ch_req,
    input  logic [NUM_CH-1:0] ch_busy,
    input  logic [NUM_CH-1:0] force_on,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] ch_ready,
    output logic [NUM_CH-1:0] gated_stat
);
    localparam int WW = $clog2(WAKE_CYC + 1);

    typedef enum logic [1:0] {ST_ON, ST_CNTDN, ST_OFF, ST_WAKE} state_t;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t            state_q;
        logic [IDLE_W-1:0] idle_q;
        logic [WW-1:0]     wake_q;
        logic              en_q;
        logic              rdy_q;
        logic              gated_q;
        logic              en_lat;
        logic              act;

        assign act = ch_req[g] | ch_busy[g] | force_on[g];

        always_ff @(posedge clk_in) begin
            if (!rst_n) begin
                state_q <= ST_ON;
                idle_q  <= '0;
                wake_q  <= '0;
                en_q    <= 1'b1;
                rdy_q   <= 1'b1;
                gated_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ON: begin
                        if (!act && idle_thresh != '0) begin
                            state_q <= ST_CNTDN;
                            idle_q  <= IDLE_W'(1);
                        end
                    end
                    ST_CNTDN: begin
                        // Activity beats the terminal count; >= covers a threshold lowered mid-count.
                        if (act || idle_thresh == '0) begin
                            state_q <= ST_ON;
                            idle_q  <= '0;
                        end else if (idle_q >= idle_thresh) begin
                            state_q <= ST_OFF;
                            idle_q  <= '0;
                            en_q    <= 1'b0;
                            rdy_q   <= 1'b0;
                            gated_q <= 1'b1;
                        end else if (idle_q != '1) begin
                            idle_q  <= idle_q + 1'b1;
                        end
                    end
                    ST_OFF: begin
                        if (act) begin
                            state_q <= ST_WAKE;
                            wake_q  <= WW'(1);
                            en_q    <= 1'b1;
                            gated_q <= 1'b0;
                        end
                    end
                    default: begin
                        if (wake_q == WW'(WAKE_CYC)) begin
                            state_q <= ST_ON;
                            wake_q  <= '0;
                            rdy_q   <= 1'b1;
                        end else begin
                            wake_q  <= wake_q + 1'b1;
                        end
                    end
                endcase
            end
        end

        // Enable can only change while clk_in is low, so the AND never chops a high pulse.
        always_latch begin
            if (!clk_in) en_lat = en_q | test_en;
        end

        assign clk_out[g]    = en_lat & clk_in;
        assign ch_ready[g]   = rdy_q;
        assign gated_stat[g] = gated_q;
    end
endmodule

// File: tb/tb_clkgate_ctrl.sv
// Randomized and directed bench for clkgate_ctrl against a cycle-level behavioural model.
module tb_clkgate_ctrl;
    localparam int NCH  = 4;
    localparam int WCYC = 2;
    localparam int M_RUN  = 0;
    localparam int M_OFF  = 1;
    localparam int M_WAKE = 2;

    logic           clk_in = 1'b0;
    logic           rst_n = 1'b0;
    logic           test_en = 1'b0;
    logic [7:0]     idle_thresh = 8'd4;
    logic [NCH-1:0] ch_req = '0, ch_busy = '0, force_on = '0;
    logic [NCH-1:0] clk_out, ch_ready, gated_stat;

    int vectors = 0;
    int miscompares = 0;
    int glitches = 0;

    int m_mode[NCH];
    int m_n[NCH];
    int m_w[NCH];
    bit m_gate_en[NCH];

    clkgate_ctrl #(.NUM_CH(NCH), .IDLE_W(8), .WAKE_CYC(WCYC)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .test_en(test_en), .idle_thresh(idle_thresh),
        .ch_req(ch_req), .ch_busy(ch_busy), .force_on(force_on),
        .clk_out(clk_out), .ch_ready(ch_ready), .gated_stat(gated_stat)
    );

    always #5 clk_in = ~clk_in;

    // Legal clk_out edges are only at clk_in edges: rises at t%10==5, falls at t%10==0.
    logic [NCH-1:0] co_prev = '0;
    always @(clk_out) begin
        for (int c = 0; c < NCH; c++) begin
            if (clk_out[c] !== co_prev[c] && $time > 20) begin
                if (clk_out[c] === 1'b1 && ($time % 10) != 5) glitches++;
                if (clk_out[c] === 1'b0 && ($time % 10) != 0) glitches++;
            end
        end
        co_prev = clk_out;
    end

    // Model: a channel is running (with a count of idle edges seen), off, or waking.
    task automatic tick();
        @(posedge clk_in);
        for (int c = 0; c < NCH; c++) begin
            bit act;
            act = ch_req[c] | ch_busy[c] | force_on[c];
            m_gate_en[c] = (m_mode[c] != M_OFF);
            if (!rst_n) begin
                m_mode[c] = M_RUN; m_n[c] = 0; m_w[c] = 0;
            end else if (m_mode[c] == M_RUN) begin
                if (act || idle_thresh == 0) m_n[c] = 0;
                else if (m_n[c] == 0) m_n[c] = 1;
                else if (m_n[c] >= int'(idle_thresh)) begin m_mode[c] = M_OFF; m_n[c] = 0; end
                else if (m_n[c] < 255) m_n[c]++;
            end else if (m_mode[c] == M_OFF) begin
                if (act) begin m_mode[c] = M_WAKE; m_w[c] = 1; end
            end else begin
                if (m_w[c] >= WCYC) begin m_mode[c] = M_RUN; m_n[c] = 0; end
                else m_w[c]++;
            end
        end
        #1;
    endtask

    // Expected {clk_out during high phase, ch_ready, gated_stat}.
    function automatic logic [3*NCH-1:0] exp_vec();
        logic [NCH-1:0] ck, rd, gt;
        for (int c = 0; c < NCH; c++) begin
            ck[c] = m_gate_en[c] | test_en;
            rd[c] = (m_mode[c] == M_RUN);
            gt[c] = (m_mode[c] == M_OFF);
        end
        return {ck, rd, gt};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; idle_thresh = 8'd4; ch_req = '0; ch_busy = '0; force_on = '0;
        repeat (3) tick();
        vectors++;
        if ({clk_out, ch_ready, gated_stat} !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", {clk_out, ch_ready, gated_stat}, exp_vec());
        end
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if ({clk_out, ch_ready, gated_stat} !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_release cyc%0d: got %h expected %h", k, {clk_out, ch_ready, gated_stat}, exp_vec());
            end
        end
        vectors++;
        if ({clk_out, ch_ready, gated_stat} !== {4'h0, 4'h0, 4'hF}) begin
            miscompares++;
            $display("FAIL reset_all_gated: got %h expected %h", {clk_out, ch_ready, gated_stat}, {4'h0, 4'h0, 4'hF});
        end
    endtask

    task automatic test_wake();
        ch_req = 4'b0100;
        tick();
        ch_req = '0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            vectors++;
            if ({clk_out, ch_ready, gated_stat} !== exp_vec()) begin
                miscompares++;
                $display("FAIL wake cyc%0d: got %h expected %h", k, {clk_out, ch_ready, gated_stat}, exp_vec());
            end
            if (k == 1) begin
                vectors++;
                if (clk_out[2] !== 1'b1 || ch_ready[2] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wake_clk_resume: clk %b rdy %b expected clk 1 rdy 0", clk_out[2], ch_ready[2]);
                end
            end
            if (k == 2) begin
                vectors++;
                if (ch_ready[2] !== 1'b1 || gated_stat !== 4'b1011) begin
                    miscompares++;
                    $display("FAIL wake_ready: rdy %b gated %b expected 1 / 1011", ch_ready[2], gated_stat);
                end
            end
        end
        vectors++;
        if (gated_stat !== 4'hF) begin
            miscompares++;
            $display("FAIL wake_regate: got %b expected 1111", gated_stat);
        end
    endtask

    task automatic test_terminal();
        ch_busy = 4'b0001;
        repeat (5) tick();
        ch_busy = '0;
        repeat (4) tick();
        ch_req = 4'b0001;
        tick();
        ch_req = '0;
        vectors++;
        if (ch_ready[0] !== 1'b1 || gated_stat[0] !== 1'b0 || {clk_out, ch_ready, gated_stat} !== exp_vec()) begin
            miscompares++;
            $display("FAIL terminal_activity_wins: got %h expected %h", {clk_out, ch_ready, gated_stat}, exp_vec());
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (gated_stat[0] !== 1'b0 || clk_out[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL terminal_hold cyc%0d: gated %b clk %b expected 0 / 1", k, gated_stat[0], clk_out[0]);
            end
        end
    endtask

    task automatic test_thresh_zero();
        idle_thresh = 8'd0;
        ch_req = 4'hF;
        tick();
        ch_req = '0;
        for (int k = 0; k < 100; k++) begin
            tick();
            vectors++;
            if ({clk_out, ch_ready, gated_stat} !== exp_vec() || (k > 3 && gated_stat !== 4'h0)) begin
                miscompares++;
                $display("FAIL thresh_zero cyc%0d: got %h expected %h", k, {clk_out, ch_ready, gated_stat}, exp_vec());
            end
        end
        idle_thresh = 8'd3;
        force_on = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            tick();
            vectors++;
            if ({clk_out, ch_ready, gated_stat} !== exp_vec() || ch_ready[1] !== 1'b1) begin
                miscompares++;
                $display("FAIL force_on cyc%0d: got %h expected %h", k, {clk_out, ch_ready, gated_stat}, exp_vec());
            end
        end
        force_on = '0;
    endtask

    task automatic test_test_en();
        idle_thresh = 8'd2;
        repeat (10) tick();
        vectors++;
        if (gated_stat !== 4'hF) begin
            miscompares++;
            $display("FAIL test_en_pre: gated %b expected 1111", gated_stat);
        end
        test_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if (clk_out !== 4'hF || gated_stat !== 4'hF || ch_ready !== 4'h0) begin
                miscompares++;
                $display("FAIL test_en_on cyc%0d: clk %b gated %b rdy %b expected 1111 1111 0000", k, clk_out, gated_stat, ch_ready);
            end
        end
        test_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (clk_out !== 4'h0 || {clk_out, ch_ready, gated_stat} !== exp_vec()) begin
                miscompares++;
                $display("FAIL test_en_off cyc%0d: got %h expected %h", k, {clk_out, ch_ready, gated_stat}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_wake();
        ch_req = 4'b1000;
        tick();
        ch_req = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (ch_ready !== 4'hF || gated_stat !== 4'h0 || {clk_out, ch_ready, gated_stat} !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_mid_wake: got %h expected %h", {clk_out, ch_ready, gated_stat}, exp_vec());
        end
        tick();
        vectors++;
        if (clk_out !== 4'hF || ch_ready[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_clk_resume: clk %b rdy3 %b expected 1111 / 1", clk_out, ch_ready[3]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            tick();
            vectors++;
            if ({clk_out, ch_ready, gated_stat} !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc%0d: got %h expected %h", k, {clk_out, ch_ready, gated_stat}, exp_vec());
            end
            #5;
            vectors++;
            if (clk_out !== 4'h0) begin
                miscompares++;
                $display("FAIL random_low cyc%0d: got %b expected 0000", k, clk_out);
            end
            for (int c = 0; c < NCH; c++) begin
                ch_req[c]   = ($urandom_range(0, 7) == 0);
                ch_busy[c]  = ($urandom_range(0, 9) == 0);
                force_on[c] = ($urandom_range(0, 39) == 0);
            end
            if ($urandom_range(0, 49) == 0) idle_thresh = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 29) == 0) test_en = ~test_en;
            rst_n = ($urandom_range(0, 199) != 0);
        end
        rst_n = 1'b1;
        test_en = 1'b0;
    endtask

    task automatic test_glitch();
        vectors++;
        if (glitches !== 0) begin
            miscompares++;
            $display("FAIL glitch_free: got %0d glitches expected 0", glitches);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = M_RUN; m_n[c] = 0; m_w[c] = 0; m_gate_en[c] = 1'b1;
        end
        test_reset();
        test_wake();
        test_terminal();
        test_thresh_zero();
        test_test_en();
        test_reset_mid_wake();
        test_random();
        test_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
